seg_frame_decoder: RTL and testbench

SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

---
 rtl/seg_frame_decoder.sv | 197 +++++++++++++++++++
 tb/tb_seg_frame_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_decoder.sv
// Snoops a multiplexed 4-digit active-low 7-segment display: each digit is captured after a
// stable anode dwell, and complete frames are presented through a valid/ready handshake.
module seg_frame_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic        frame_ready,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic        frame_valid,
  output logic        timeout
);

  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYCLES);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        anode_q, anode_d;
  logic [StabW-1:0]  stab_q, stab_d;
  logic [IdleW-1:0]  idle_q, idle_d, idle_inc;
  logic [3:0]        seen_q, seen_d;
  logic [15:0]       digits_q, digits_d;
  logic [3:0]        dps_q, dps_d;
  logic [3:0]        blank_q, blank_d;
  logic [3:0]        bad_q, bad_d;
  logic              frame_valid_q, frame_valid_d;
  logic              timeout_q, timeout_d;

  logic [6:0] pat;
  logic [3:0] dec_val;
  logic       dec_hit;
  logic       is_blank;
  logic       anode_ok;
  logic [1:0] sel;
  logic       same;
  logic       capture;
  logic       take;

  always_comb begin
    pat     = {g, f, e, d, c, b, a};
    dec_val = 4'h0;
    dec_hit = 1'b1;
    case (pat)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      default: dec_hit = 1'b0;
    endcase
    is_blank = (pat == 7'h7F);
  end

  always_comb begin
    anode_ok = 1'b1;
    sel      = 2'd0;
    unique case (anode)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: anode_ok = 1'b0;
    endcase
  end

  // Dwell counter saturates at STABLE_CYCLES so each dwell captures exactly once.
  always_comb begin
    anode_d = anode;
    same    = anode_ok && (anode == anode_q);
    stab_d  = '0;
    if (anode_ok) begin
      if (!same)                 stab_d = StabW'(1);
      else if (stab_q == StabMax) stab_d = stab_q;
      else                        stab_d = stab_q + 1'b1;
    end
    capture = anode_ok && (stab_d == StabMax) && !(same && (stab_q == StabMax));
  end

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    idle_inc  = idle_q + 1'b1;
    seen_d    = seen_q;
    digits_d  = digits_q;
    dps_d     = dps_q;
    blank_d   = blank_q;
    bad_d     = bad_q;
    timeout_d = 1'b0;
    take      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (anode_ok) begin
          state_d = StScan;
          take    = capture;
        end
      end
      StScan: begin
        take = capture;
        if (capture) begin
          idle_d = '0;
        end else if (idle_inc == IdleMax) begin
          timeout_d = 1'b1;
          seen_d    = '0;
          idle_d    = '0;
        end else begin
          idle_d = idle_inc;
        end
      end
      StHold: begin
        // A capture coinciding with the handshake opens the next frame.
        if (frame_ready) begin
          state_d = StScan;
          seen_d  = '0;
          idle_d  = '0;
          take    = capture;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      digits_d[{sel, 2'b00} +: 4] = dec_val;
      dps_d[sel]   = ~dp;
      blank_d[sel] = is_blank;
      bad_d[sel]   = !is_blank && !dec_hit;
      seen_d[sel]  = 1'b1;
      if (state_q != StHold && seen_d == 4'hF) state_d = StHold;
    end

    frame_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      anode_q       <= 4'hF;
      stab_q        <= '0;
      idle_q        <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      dps_q         <= '0;
      blank_q       <= '0;
      bad_q         <= '0;
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      anode_q       <= anode_d;
      stab_q        <= stab_d;
      idle_q        <= idle_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      dps_q         <= dps_d;
      blank_q       <= blank_d;
      bad_q         <= bad_d;
      frame_valid_q <= frame_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign digits      = digits_q;
  assign dps         = dps_q;
  assign blank       = blank_q;
  assign bad         = bad_q;
  assign frame_valid = frame_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Scoreboard bench for seg_frame_decoder: stimulus tasks feed a digit-level reference model
// that queues expected frames and timeout cycles; a negedge monitor pops and compares.
module tb_seg_frame_decoder;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TOUT   = 50;
  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blank;
    logic [3:0]  bad;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  anode;
  logic        a, b, c, d, e, f, g, dp;
  logic        frame_ready;
  logic [15:0] digits;
  logic [3:0]  dps, blank, bad;
  logic        frame_valid, timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  frame_t exp_q[$];
  int     exp_to_q[$];

  logic [3:0] m_val [4];
  logic [3:0] m_dp, m_blank, m_bad, m_seen;
  bit         m_hold, stall;
  int         last_cap;
  logic [3:0] last_an;

  seg_frame_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .anode(anode),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .frame_ready(frame_ready), .digits(digits), .dps(dps), .blank(blank), .bad(bad),
    .frame_valid(frame_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 0);
    check({tag, "_dps"}, 32'(dps), 0);
    check({tag, "_blank"}, 32'(blank), 0);
    check({tag, "_bad"}, 32'(bad), 0);
    check({tag, "_frame_valid"}, 32'(frame_valid), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one call per dwell long enough to be captured.
  task automatic model_capture(input int idx, input logic [6:0] pat, input logic dpb,
                               input int at);
    frame_t fr;
    if (m_hold) return;
    last_cap     = at;
    m_val[idx]   = 4'h0;
    m_blank[idx] = (pat == 7'h7F);
    m_bad[idx]   = 1'b0;
    if (!m_blank[idx]) begin
      m_bad[idx] = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (TBL[i] == pat) begin
          m_val[idx] = 4'(i);
          m_bad[idx] = 1'b0;
        end
      end
    end
    m_dp[idx]   = dpb;
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      fr.digits = {m_val[3], m_val[2], m_val[1], m_val[0]};
      fr.dps    = m_dp;
      fr.blank  = m_blank;
      fr.bad    = m_bad;
      exp_q.push_back(fr);
      m_seen = 4'h0;
      m_hold = stall;
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] pat, input logic dpb,
                       input int len);
    int idx;
    idx = -1;
    if ($countones(~an) == 1) begin
      for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
    end
    anode = an;
    {g, f, e, d, c, b, a} = pat;
    dp = ~dpb;
    last_an = an;
    if (idx >= 0 && len >= int'(STABLE)) model_capture(idx, pat, dpb, cyc + int'(STABLE));
    repeat (len) step();
  endtask

  task automatic gap(input logic [3:0] an, input int len);
    anode   = an;
    last_an = an;
    repeat (len) step();
  endtask

  initial begin : monitor
    frame_t cur;
    bit have, fv_prev, rdy_prev;
    have = 0; fv_prev = 0; rdy_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 0; fv_prev = 0; rdy_prev = 0;
      end else begin
        if (frame_valid && !fv_prev) begin
          check("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur  = exp_q.pop_front();
            have = 1;
          end
        end
        if (frame_valid && have) begin
          check("frame_digits", 32'(digits), 32'(cur.digits));
          check("frame_dps", 32'(dps), 32'(cur.dps));
          check("frame_blank", 32'(blank), 32'(cur.blank));
          check("frame_bad", 32'(bad), 32'(cur.bad));
        end
        if (fv_prev) begin
          if (rdy_prev) check("fv_drop_after_accept", 32'(frame_valid), 0);
          else          check("fv_held_while_stalled", 32'(frame_valid), 1);
        end
        if (timeout) begin
          check("timeout_expected", 32'(exp_to_q.size() != 0), 1);
          if (exp_to_q.size() != 0) check("timeout_cycle", 32'(cyc), 32'(exp_to_q.pop_front()));
        end
        fv_prev  = frame_valid;
        rdy_prev = frame_ready;
      end
    end
  end

  initial begin : stimulus
    logic [3:0] an, inv;
    logic [6:0] p;
    int shorts, len, idx;
    rst_n = 1'b0; anode = 4'hF; {g, f, e, d, c, b, a} = 7'h7F; dp = 1'b1;
    frame_ready = 1'b1; m_seen = 0; m_hold = 0; stall = 0; last_an = 4'hF; last_cap = 0;
    m_dp = 0; m_blank = 0; m_bad = 0;
    for (int i = 0; i < 4; i++) m_val[i] = 0;
    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Basic frame 1,2,3,4 with dp on digit 2.
    dwell(4'b1110, 7'h79, 1'b0, 6);
    dwell(4'b1101, 7'h24, 1'b0, 6);
    dwell(4'b1011, 7'h30, 1'b1, 6);
    dwell(4'b0111, 7'h19, 1'b0, 6);
    gap(4'hF, 2);

    // Three-cycle dwells never capture; four-cycle dwells do.
    dwell(4'b1110, 7'h40, 1'b0, 3);
    dwell(4'b1101, 7'h79, 1'b1, 3);
    dwell(4'b1011, 7'h24, 1'b0, 3);
    dwell(4'b0111, 7'h30, 1'b1, 3);
    dwell(4'b1110, 7'h12, 1'b0, 4);
    dwell(4'b1101, 7'h02, 1'b0, 4);
    dwell(4'b1011, 7'h78, 1'b0, 4);
    dwell(4'b0111, 7'h00, 1'b1, 4);
    gap(4'hF, 2);

    // Consumer stalls while the display keeps changing.
    frame_ready = 1'b0; stall = 1;
    dwell(4'b1110, 7'h10, 1'b0, 5);
    dwell(4'b1101, 7'h08, 1'b1, 5);
    dwell(4'b1011, 7'h03, 1'b0, 5);
    dwell(4'b0111, 7'h46, 1'b0, 5);
    dwell(4'b1110, 7'h21, 1'b1, 5);
    dwell(4'b1101, 7'h06, 1'b0, 5);
    dwell(4'b1011, 7'h0E, 1'b1, 5);
    dwell(4'b0111, 7'h40, 1'b0, 5);
    gap(4'hF, 1);
    frame_ready = 1'b1; stall = 0; m_hold = 0;
    gap(4'hF, 2);

    // Blank and bad patterns; invalid anodes break a dwell.
    dwell(4'b1110, 7'h7F, 1'b0, 4);
    dwell(4'b1101, 7'h55, 1'b1, 5);
    dwell(4'b1011, 7'h19, 1'b0, 4);
    dwell(4'b1110, 7'h79, 1'b0, 3);
    gap(4'b1100, 2);
    dwell(4'b1110, 7'h79, 1'b0, 3);
    gap(4'hF, 1);
    dwell(4'b1110, 7'h79, 1'b0, 3);
    dwell(4'b0111, 7'h06, 1'b0, 4);
    gap(4'hF, 2);

    // Partial frame abandoned after TOUT idle cycles.
    dwell(4'b1110, 7'h79, 1'b0, 4);
    dwell(4'b1101, 7'h24, 1'b0, 4);
    exp_to_q.push_back(last_cap + int'(TOUT));
    m_seen = 4'h0;
    gap(4'hF, int'(TOUT) + 2);
    dwell(4'b1011, 7'h30, 1'b0, 4);
    dwell(4'b0111, 7'h19, 1'b0, 4);
    dwell(4'b1110, 7'h12, 1'b0, 4);
    dwell(4'b1101, 7'h02, 1'b0, 4);
    gap(4'hF, 2);

    // Reset mid-dwell; the dwell held across release must restart its count.
    anode = 4'b1011; {g, f, e, d, c, b, a} = 7'h24; dp = 1'b1; last_an = 4'b1011;
    step(); step();
    rst_n = 1'b0;
    #1;
    check_zero("rst_dwell");
    m_seen = 0; m_hold = 0;
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    {g, f, e, d, c, b, a} = 7'h30;
    model_capture(2, 7'h30, 1'b0, cyc + 1);
    repeat (3) step();
    dwell(4'b0111, 7'h19, 1'b0, 4);
    dwell(4'b1110, 7'h79, 1'b0, 4);
    dwell(4'b1101, 7'h24, 1'b0, 4);
    gap(4'hF, 2);

    // Reset while a frame is held.
    frame_ready = 1'b0; stall = 1;
    dwell(4'b1110, 7'h08, 1'b0, 4);
    dwell(4'b1101, 7'h03, 1'b1, 4);
    dwell(4'b1011, 7'h46, 1'b0, 4);
    dwell(4'b0111, 7'h21, 1'b0, 4);
    gap(4'hF, 3);
    rst_n = 1'b0;
    #1;
    check_zero("rst_hold");
    m_seen = 0; m_hold = 0; stall = 0;
    step(); step();
    rst_n = 1'b1; frame_ready = 1'b1;
    step();

    // Randomized scanning; at most three non-capturing items between captures.
    shorts = 0;
    for (int n = 0; n < 150; n++) begin
      if (shorts < 3 && $urandom_range(0, 9) < 2) begin
        do inv = 4'($urandom); while ($countones(~inv) == 1);
        gap(inv, $urandom_range(1, 3));
        shorts++;
      end else begin
        do begin
          idx = $urandom_range(0, 3);
          an = 4'hF;
          an[idx] = 1'b0;
        end while (an == last_an);
        case ($urandom_range(0, 9))
          8:       p = 7'h7F;
          9:       p = 7'($urandom);
          default: p = TBL[$urandom_range(0, 15)];
        endcase
        len = (shorts >= 3) ? $urandom_range(4, 8) : $urandom_range(3, 8);
        dwell(an, p, 1'($urandom), len);
        shorts = (len < int'(STABLE)) ? shorts + 1 : 0;
      end
    end
    gap(4'hF, 5);

    check("frames_pending", 32'(exp_q.size()), 0);
    check("timeouts_pending", 32'(exp_to_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
